// File: rtl/berger_mem_ctrl.sv
// berger_mem_ctrl: access controller for a Berger-coded memory.
// Arbitrates a host port (priority) against a background scrubber and
// keeps an error log (saturating count, sticky first address, irq).
// Optional macro BERGER_READ_RETRY_EN: a read whose first check shows
// an error is re-issued once and only the second result is final.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   host_req/we/addr/wdata   host request (held until host_ack)
//   host_ack/rdata/err       host completion pulse, read data, error
//   scrub_en, err_clr        scrubber enable, error log clear
//   mem_addr/wdata/wr_en     memory command (read latency 1)
//   mem_rdata, mem_err       memory read data and error_detected
//   err_count/addr/addr_valid, irq, scrub_pass_done   status outputs
module berger_mem_ctrl #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 4,
  parameter int SCRUB_INTERVAL = 64,
  parameter int ERR_CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_err,
  input  logic              scrub_en,
  input  logic              err_clr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr_en,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [ADDR_W-1:0] err_addr,
  output logic              err_addr_valid,
  output logic              irq,
  output logic              scrub_pass_done
);

  localparam int TW = $clog2(SCRUB_INTERVAL);
  localparam logic [TW-1:0] RELOAD = TW'(SCRUB_INTERVAL - 1);
  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

`ifdef BERGER_READ_RETRY_EN
  typedef enum logic [2:0] {
    IDLE, WR, RD, CHK, RETRY
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, WR, RD, CHK
  } state_t;
`endif

  state_t state, state_nxt;

  logic              owner_scrub;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-1:0] scrub_ptr;
  logic [TW-1:0]     timer;
  logic              scrub_due;

  logic take_host;
  logic take_scrub;
  logic fin;
  logic fin_err;
`ifdef BERGER_READ_RETRY_EN
  logic retried;
  logic retry_go;
`endif

  assign mem_addr = addr_q;
  assign irq      = err_addr_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    host_ack        = 1'b0;
    host_rdata      = '0;
    host_err        = 1'b0;
    mem_wr_en       = 1'b0;
    mem_wdata       = '0;
    scrub_pass_done = 1'b0;
    take_host       = 1'b0;
    take_scrub      = 1'b0;
    fin             = 1'b0;
    fin_err         = 1'b0;
`ifdef BERGER_READ_RETRY_EN
    retry_go        = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (host_req) begin
          take_host = 1'b1;
          state_nxt = host_we ? WR : RD;
        end else if (scrub_due) begin
          take_scrub = 1'b1;
          state_nxt  = RD;
        end
      end
      WR: begin
        mem_wr_en = 1'b1;
        mem_wdata = wdata_q;
        host_ack  = 1'b1;
        state_nxt = IDLE;
      end
      RD: begin
        state_nxt = CHK;
      end
      CHK: begin
`ifdef BERGER_READ_RETRY_EN
        if (mem_err && !retried) begin
          retry_go  = 1'b1;
          state_nxt = RETRY;
        end else begin
          fin = 1'b1;
        end
`else
        fin = 1'b1;
`endif
        if (fin) begin
          state_nxt = IDLE;
          fin_err   = mem_err;
          if (!owner_scrub) begin
            host_ack   = 1'b1;
            host_rdata = mem_rdata;
            host_err   = mem_err;
          end else if (scrub_ptr == PTR_LAST) begin
            scrub_pass_done = 1'b1;
          end
        end
      end
`ifdef BERGER_READ_RETRY_EN
      RETRY: begin
        state_nxt = CHK;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Access context is latched on leaving IDLE so the memory
  // address stays stable for the whole access.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_scrub <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      scrub_ptr   <= '0;
    end else begin
      if (take_host) begin
        owner_scrub <= 1'b0;
        addr_q      <= host_addr;
        wdata_q     <= host_wdata;
      end else if (take_scrub) begin
        owner_scrub <= 1'b1;
        addr_q      <= scrub_ptr;
      end
      if (fin && owner_scrub)
        scrub_ptr <= scrub_ptr + ADDR_W'(1);
    end
  end

`ifdef BERGER_READ_RETRY_EN
  always_ff @(posedge clk) begin
    if (rst || take_host || take_scrub) retried <= 1'b0;
    else if (retry_go)                  retried <= 1'b1;
  end
`endif

  // A new expiry wins over the clear on issue, so at most one
  // scrub read is ever pending.
  always_ff @(posedge clk) begin
    if (rst || !scrub_en) begin
      timer     <= RELOAD;
      scrub_due <= 1'b0;
    end else begin
      timer     <= (timer == '0) ? RELOAD : timer - TW'(1);
      scrub_due <= (timer == '0) | (scrub_due & ~take_scrub);
    end
  end

  // A final error in the same cycle as a clear starts a fresh log.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count      <= '0;
      err_addr       <= '0;
      err_addr_valid <= 1'b0;
    end else if (fin_err) begin
      if (err_clr)
        err_count <= ERR_CNT_W'(1);
      else if (err_count != '1)
        err_count <= err_count + ERR_CNT_W'(1);
      if (err_clr || !err_addr_valid) begin
        err_addr       <= addr_q;
        err_addr_valid <= 1'b1;
      end
    end else if (err_clr) begin
      err_count      <= '0;
      err_addr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_berger_mem_ctrl.sv
// tb_berger_mem_ctrl: directed and randomized bench for berger_mem_ctrl.
// Memory is a behavioural array with per-address error injection.
module tb_berger_mem_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int CW = 2;
  localparam int CNT_MAX = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ack;
  logic [DW-1:0] host_rdata;
  logic          host_err;
  logic          scrub_en;
  logic          err_clr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wr_en;
  logic [DW-1:0] mem_rdata;
  logic          mem_err;
  logic [CW-1:0] err_count;
  logic [AW-1:0] err_addr;
  logic          err_addr_valid;
  logic          irq;
  logic          scrub_pass_done;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  berger_mem_ctrl #(
    .DATA_W(DW), .ADDR_W(AW),
    .SCRUB_INTERVAL(4), .ERR_CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .host_err(host_err),
    .scrub_en(scrub_en), .err_clr(err_clr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wr_en(mem_wr_en), .mem_rdata(mem_rdata),
    .mem_err(mem_err),
    .err_count(err_count), .err_addr(err_addr),
    .err_addr_valid(err_addr_valid), .irq(irq),
    .scrub_pass_done(scrub_pass_done)
  );

  logic [DW-1:0] mem [16];
  bit            corrupt [16];

  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
    mem_err   <= corrupt[mem_addr];
  end

  logic [DW-1:0] ref_mem [16];
  int ref_cnt;
  int ref_first;
  bit ref_valid;

  function automatic void ref_error(input int a);
    ref_cnt = (ref_cnt < CNT_MAX) ? ref_cnt + 1 : CNT_MAX;
    if (!ref_valid) begin
      ref_first = a;
      ref_valid = 1'b1;
    end
  endfunction

  function automatic int rd_lat(input bit first_err);
`ifdef BERGER_READ_RETRY_EN
    return first_err ? 4 : 2;
`else
    return 2;
`endif
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    host_req = 1'b0;
    host_we = 1'b0;
    host_addr = '0;
    host_wdata = '0;
    scrub_en = 1'b0;
    err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    ref_cnt = 0;
    ref_first = 0;
    ref_valid = 1'b0;
  endtask

  task automatic host_op(input bit we, input int a,
                         input logic [DW-1:0] wd,
                         input bit clr_at_ack,
                         output int lat,
                         output logic [DW-1:0] rd,
                         output logic er);
    tick();
    host_req = 1'b1;
    host_we = we;
    host_addr = AW'(a);
    host_wdata = wd;
    lat = -1;
    rd = '0;
    er = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (host_ack) begin
        lat = n;
        rd = host_rdata;
        er = host_err;
        host_req = 1'b0;
        if (clr_at_ack) err_clr = 1'b1;
        break;
      end
    end
    if (lat < 0) begin
      host_req = 1'b0;
      chk("ack_timeout", 32'(host_ack), 1);
    end
    if (clr_at_ack) begin
      tick();
      err_clr = 1'b0;
    end
  endtask

  task automatic check_log(input string tag);
    tick();
    chk({tag, "_cnt"}, 32'(err_count), ref_cnt);
    chk({tag, "_valid"}, 32'(err_addr_valid), 32'(ref_valid));
    chk({tag, "_irq"}, 32'(irq), 32'(ref_valid));
    if (ref_valid)
      chk({tag, "_addr"}, 32'(err_addr), ref_first);
  endtask

  task automatic ref_write(input int a, input logic [DW-1:0] d);
    int lat;
    logic [DW-1:0] rd;
    logic er;
    host_op(1'b1, a, d, 1'b0, lat, rd, er);
    chk("wr_lat", lat, 1);
    ref_mem[a] = d;
  endtask

  task automatic ref_read(input int a, input string tag);
    int lat;
    logic [DW-1:0] rd;
    logic er;
    bit bad;
    bad = corrupt[a];
    host_op(1'b0, a, '0, 1'b0, lat, rd, er);
    chk({tag, "_lat"}, lat, rd_lat(bad));
    chk({tag, "_rdata"}, 32'(rd), 32'(ref_mem[a]));
    chk({tag, "_err"}, 32'(er), 32'(bad));
    if (bad) ref_error(a);
    check_log(tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [DW-1:0] rd;
    logic er;
    for (int i = 0; i < 16; i++) corrupt[i] = 1'b0;

    // Reset values
    do_reset();
    chk("rst_ack", 32'(host_ack), 0);
    chk("rst_rdata", 32'(host_rdata), 0);
    chk("rst_herr", 32'(host_err), 0);
    chk("rst_maddr", 32'(mem_addr), 0);
    chk("rst_mwdata", 32'(mem_wdata), 0);
    chk("rst_wren", 32'(mem_wr_en), 0);
    chk("rst_cnt", 32'(err_count), 0);
    chk("rst_eaddr", 32'(err_addr), 0);
    chk("rst_valid", 32'(err_addr_valid), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_pass", 32'(scrub_pass_done), 0);

    // Scrub walk: read k is in RD at E+5+4k, CHK one cycle later
    scrub_en = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      tick();
      if (c >= 5 && ((c - 5) % 4) < 2)
        chk($sformatf("scrub_addr_c%0d", c), 32'(mem_addr),
            ((c - 5) / 4) % 16);
      chk($sformatf("scrub_pass_c%0d", c), 32'(scrub_pass_done),
          32'(c == 66));
      chk($sformatf("scrub_noack_c%0d", c), 32'(host_ack), 0);
    end
    scrub_en = 1'b0;

    // Host request in the cycle scrub_due rises wins
    do_reset();
    scrub_en = 1'b1;
    repeat (4) tick();
    host_req = 1'b1;
    host_we = 1'b0;
    host_addr = 4'd9;
    tick();
    chk("prio_rd_addr", 32'(mem_addr), 9);
    chk("prio_noack", 32'(host_ack), 0);
    tick();
    chk("prio_ack", 32'(host_ack), 1);
    host_req = 1'b0;
    tick();
    tick();
    chk("prio_scrub_addr", 32'(mem_addr), 0);
    tick();
    chk("prio_scrub_chk", 32'(mem_addr), 0);
    chk("prio_scrub_noack", 32'(host_ack), 0);
    scrub_en = 1'b0;
    repeat (3) tick();

    // Fill memory, then write/read 0xA5 at addr 3
    do_reset();
    for (int a = 0; a < 16; a++)
      ref_write(a, DW'($urandom));
    ref_write(3, 8'hA5);
    ref_read(3, "a5");

    // Persistent errors: count 1 then 2, first address sticks at 1
    corrupt[1] = 1'b1;
    ref_read(1, "err1");
    corrupt[1] = 1'b0;
    corrupt[5] = 1'b1;
    ref_read(5, "err5");
    corrupt[5] = 1'b0;

    // Error on first read attempt only
    tick();
    corrupt[2] = 1'b1;
    host_req = 1'b1;
    host_we = 1'b0;
    host_addr = 4'd2;
    tick();
    chk("once_t1", 32'(host_ack), 0);
    tick();
    corrupt[2] = 1'b0;
`ifdef BERGER_READ_RETRY_EN
    chk("once_t2", 32'(host_ack), 0);
    tick();
    chk("once_t3", 32'(host_ack), 0);
    tick();
    chk("once_ack", 32'(host_ack), 1);
    chk("once_err", 32'(host_err), 0);
    chk("once_rdata", 32'(host_rdata), 32'(ref_mem[2]));
`else
    chk("once_ack", 32'(host_ack), 1);
    chk("once_err", 32'(host_err), 1);
    chk("once_rdata", 32'(host_rdata), 32'(ref_mem[2]));
    ref_error(2);
`endif
    host_req = 1'b0;
    check_log("once");

    // Clear, then saturate a 2-bit counter
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    ref_cnt = 0;
    ref_valid = 1'b0;
    check_log("clr");
    for (int i = 0; i < 5; i++) begin
      corrupt[i] = 1'b1;
      ref_read(i, $sformatf("sat%0d", i));
      corrupt[i] = 1'b0;
    end

    // Clear coinciding with a failing read of addr 7
    corrupt[7] = 1'b1;
    host_op(1'b0, 7, '0, 1'b1, lat, rd, er);
    corrupt[7] = 1'b0;
    chk("clr7_lat", lat, rd_lat(1'b1));
    chk("clr7_err", 32'(er), 1);
    ref_cnt = 1;
    ref_first = 7;
    ref_valid = 1'b1;
    chk("clr7_cnt", 32'(err_count), ref_cnt);
    chk("clr7_addr", 32'(err_addr), ref_first);
    chk("clr7_valid", 32'(err_addr_valid), 1);

    // Randomized host traffic against the reference model
    for (int i = 0; i < 40; i++) begin
      int a;
      a = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        ref_write(a, DW'($urandom));
      end else begin
        corrupt[a] = ($urandom_range(0, 3) == 0);
        ref_read(a, $sformatf("rnd%0d", i));
        corrupt[a] = 1'b0;
      end
      if (i % 10 == 9) begin
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        ref_cnt = 0;
        ref_valid = 1'b0;
        check_log($sformatf("rclr%0d", i));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
